// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: frames the UART receive byte stream into command packets
// of the form START, CMD, LEN, LEN payload bytes, END. A completed packet is held
// behind a valid/ack handshake. Malformed frames, oversize LEN, inter-byte
// timeouts and overruns are flagged with one-cycle pulses and discarded.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   rx_data, rx_valid        byte stream from the UART receiver
//   pkt_ack                  consumer has taken the held packet
//   rd_addr, rd_data         payload read port (rd_data combinational, 0 past LEN)
//   cmd_out, len_out         CMD and LEN of the held / last presented packet
//   pkt_valid                level, a complete packet is held
//   busy                     receiving a frame (CMD, LEN, DATA, END)
//   frame_err, len_err,
//   timeout_err, overrun_err one-cycle error pulses
module uart_rx_packet_ctrl #(
  parameter int unsigned              WORD_LENGHT    = 8,
  parameter int unsigned              MAX_PAYLOAD    = 16,
  parameter logic [WORD_LENGHT-1:0]   START_BYTE     = 8'hFE,
  parameter logic [WORD_LENGHT-1:0]   END_BYTE       = 8'hEF,
  parameter int unsigned              TIMEOUT_CYCLES = 104166
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WORD_LENGHT-1:0]             rx_data,
  input  logic                               rx_valid,
  input  logic                               pkt_ack,
  input  logic [$clog2(MAX_PAYLOAD)-1:0]     rd_addr,
  output logic [WORD_LENGHT-1:0]             rd_data,
  output logic [WORD_LENGHT-1:0]             cmd_out,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0]   len_out,
  output logic                               pkt_valid,
  output logic                               busy,
  output logic                               frame_err,
  output logic                               len_err,
  output logic                               timeout_err,
  output logic                               overrun_err
);

  localparam int unsigned AW = $clog2(MAX_PAYLOAD);
  localparam int unsigned LW = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_END  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [WORD_LENGHT-1:0] cmd_sh_q, cmd_sh_d;
  logic [LW-1:0]          len_sh_q, len_sh_d;
  logic [LW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [WORD_LENGHT-1:0] cmd_out_q, cmd_out_d;
  logic [LW-1:0]          len_out_q, len_out_d;
  logic [WORD_LENGHT-1:0] payload_q [MAX_PAYLOAD];
  logic [WORD_LENGHT-1:0] payload_d [MAX_PAYLOAD];
  logic                   pkt_valid_q, pkt_valid_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   len_err_q, len_err_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   in_frame_c;

  assign in_frame_c = (state_q == S_CMD) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_END);

  // Next-state, datapath and error-pulse logic
  always_comb begin
    state_d       = state_q;
    cmd_sh_d      = cmd_sh_q;
    len_sh_d      = len_sh_q;
    idx_d         = idx_q;
    to_cnt_d      = '0;
    cmd_out_d     = cmd_out_q;
    len_out_d     = len_out_q;
    payload_d     = payload_q;
    frame_err_d   = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;

    // Inter-byte timer; a byte in the terminal cycle wins over the timeout
    if (in_frame_c && !rx_valid) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_err_d = 1'b1;
        state_d       = S_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == START_BYTE)) state_d = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_sh_d = rx_data;
          state_d  = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data > WORD_LENGHT'(MAX_PAYLOAD)) begin
            len_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_sh_d = LW'(rx_data);
            idx_d    = '0;
            state_d  = (rx_data == '0) ? S_END : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          payload_d[idx_q[AW-1:0]] = rx_data;
          idx_d                    = idx_q + LW'(1);
          if ((idx_q + LW'(1)) == len_sh_q) state_d = S_END;
        end
      end
      S_END: begin
        if (rx_valid) begin
          if (rx_data == END_BYTE) begin
            cmd_out_d = cmd_sh_q;
            len_out_d = len_sh_q;
            state_d   = S_HOLD;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // Ack takes priority; a coincident byte is treated as if seen in IDLE
        if (pkt_ack) begin
          state_d = (rx_valid && (rx_data == START_BYTE)) ? S_CMD : S_IDLE;
        end else if (rx_valid) begin
          overrun_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pkt_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d == S_CMD) || (state_d == S_LEN) ||
                  (state_d == S_DATA) || (state_d == S_END);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cmd_sh_q      <= '0;
      len_sh_q      <= '0;
      idx_q         <= '0;
      to_cnt_q      <= '0;
      cmd_out_q     <= '0;
      len_out_q     <= '0;
      pkt_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      for (int i = 0; i < int'(MAX_PAYLOAD); i++) payload_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      cmd_sh_q      <= cmd_sh_d;
      len_sh_q      <= len_sh_d;
      idx_q         <= idx_d;
      to_cnt_q      <= to_cnt_d;
      cmd_out_q     <= cmd_out_d;
      len_out_q     <= len_out_d;
      pkt_valid_q   <= pkt_valid_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      for (int i = 0; i < int'(MAX_PAYLOAD); i++) payload_q[i] <= payload_d[i];
    end
  end

  // Payload read port, zero beyond the presented length
  assign rd_data = (LW'(rd_addr) < len_out_q) ? payload_q[rd_addr] : '0;

  assign cmd_out     = cmd_out_q;
  assign len_out     = len_out_q;
  assign pkt_valid   = pkt_valid_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign len_err     = len_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Self-checking bench for uart_rx_packet_ctrl: expected packets are queued as
// frames are driven and compared when the DUT presents them.
module tb_uart_rx_packet_ctrl;

  localparam int unsigned WL = 8;
  localparam int unsigned MP = 16;
  localparam int unsigned TO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] rx_data;
  logic          rx_valid;
  logic          pkt_ack;
  logic [3:0]    rd_addr;
  logic [WL-1:0] rd_data;
  logic [WL-1:0] cmd_out;
  logic [4:0]    len_out;
  logic          pkt_valid, busy, frame_err, len_err, timeout_err, overrun_err;

  always #5 clk = ~clk;

  uart_rx_packet_ctrl #(
    .WORD_LENGHT   (WL),
    .MAX_PAYLOAD   (MP),
    .START_BYTE    (8'hFE),
    .END_BYTE      (8'hEF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pkt_ack    (pkt_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cmd_out    (cmd_out),
    .len_out    (len_out),
    .pkt_valid  (pkt_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .len_err    (len_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  logic [7:0]  exp_q[$];
  logic [7:0]  stim_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; strobes one byte and returns at the next negedge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_stim();
    while (stim_q.size() > 0) send_byte(stim_q.pop_front());
  endtask

  // Pop the next expected packet and compare it with what the DUT holds
  task automatic expect_pkt();
    logic [7:0] c, l;
    check("pkt_valid", pkt_valid, 1);
    if (exp_q.size() < 2) begin
      check("sb_underflow", exp_q.size(), 2);
      return;
    end
    c = exp_q.pop_front();
    l = exp_q.pop_front();
    check("cmd_out", cmd_out, c);
    check("len_out", len_out, l);
    for (int i = 0; i < int'(l); i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("rd_data[%0d]", i), rd_data, exp_q.pop_front());
    end
    if (l < 8'(MP)) begin
      rd_addr = 4'(l);
      #1;
      check("rd_data_oob", rd_data, 0);
    end
    rd_addr = '0;
    @(negedge clk);
  endtask

  task automatic ack_pkt();
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    check("ack_drops_valid", pkt_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; pkt_ack = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {cmd_out, len_out, pkt_valid, busy, frame_err, len_err, timeout_err, overrun_err, rd_data},
          0);
    rst = 1'b1;
    @(negedge clk);

    // Basic 3-byte packet
    exp_q.push_back(8'h05); exp_q.push_back(8'h03);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    stim_q = '{8'hFE, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33};
    send_stim();
    check("busy_in_end", busy, 1);
    check("valid_before_end", pkt_valid, 0);
    send_byte(8'hEF);
    expect_pkt();
    ack_pkt();
    check("busy_after_ack", busy, 0);

    // Zero-length packet, then oversize LEN
    exp_q.push_back(8'h07); exp_q.push_back(8'h00);
    stim_q = '{8'hFE, 8'h07, 8'h00, 8'hEF};
    send_stim();
    expect_pkt();
    ack_pkt();
    stim_q = '{8'hFE, 8'h01, 8'h11};
    send_stim();
    check("len_err_pulse", len_err, 1);
    check("len_err_busy", busy, 0);
    check("cmd_held_after_ack", cmd_out, 8'h07);
    @(negedge clk);
    check("len_err_one_cycle", len_err, 0);

    // Wrong END byte
    stim_q = '{8'hFE, 8'h02, 8'h01, 8'hAA};
    send_stim();
    check("busy_before_bad_end", busy, 1);
    send_byte(8'h55);
    check("frame_err_pulse", frame_err, 1);
    check("frame_err_valid", pkt_valid, 0);
    check("frame_err_busy", busy, 0);
    @(negedge clk);
    check("frame_err_one_cycle", frame_err, 0);

    // Inter-byte timeout fires on the 50th silent cycle
    stim_q = '{8'hFE, 8'h02};
    send_stim();
    repeat (TO - 1) @(negedge clk);
    check("no_timeout_yet", timeout_err, 0);
    check("busy_before_timeout", busy, 1);
    @(negedge clk);
    check("timeout_pulse", timeout_err, 1);
    check("timeout_busy", busy, 0);
    @(negedge clk);
    check("timeout_one_cycle", timeout_err, 0);

    // Byte in the terminal cycle is accepted
    exp_q.push_back(8'h02); exp_q.push_back(8'h00);
    stim_q = '{8'hFE, 8'h02};
    send_stim();
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h00);
    check("late_byte_no_timeout", timeout_err, 0);
    check("late_byte_busy", busy, 1);
    repeat (10) @(negedge clk);
    send_byte(8'hEF);
    expect_pkt();
    ack_pkt();

    // Overrun in HOLD, then START together with ack
    exp_q.push_back(8'h03); exp_q.push_back(8'h02);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    stim_q = '{8'hFE, 8'h03, 8'h02, 8'hA1, 8'hB2, 8'hEF};
    send_stim();
    expect_pkt();
    send_byte(8'h3C);
    check("overrun_pulse", overrun_err, 1);
    check("overrun_valid", pkt_valid, 1);
    rd_addr = 4'd0; #1;
    check("overrun_buf0", rd_data, 8'hA1);
    rd_addr = 4'd1; #1;
    check("overrun_buf1", rd_data, 8'hB2);
    rd_addr = 4'd0;
    check("overrun_len", len_out, 2);
    @(negedge clk);
    check("overrun_one_cycle", overrun_err, 0);
    pkt_ack  = 1'b1;
    rx_data  = 8'hFE;
    rx_valid = 1'b1;
    @(negedge clk);
    pkt_ack  = 1'b0;
    rx_valid = 1'b0;
    check("ack_start_valid", pkt_valid, 0);
    check("ack_start_busy", busy, 1);
    check("ack_start_no_overrun", overrun_err, 0);
    check("ack_start_cmd_held", cmd_out, 8'h03);
    exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    stim_q = '{8'h04, 8'h00, 8'hEF};
    send_stim();
    expect_pkt();
    ack_pkt();

    // Reset in the middle of a payload
    stim_q = '{8'hFE, 8'h08, 8'h04, 8'h01, 8'h02};
    send_stim();
    rst = 1'b0;
    #1;
    check("midrst_outputs",
          {cmd_out, len_out, pkt_valid, busy, frame_err, len_err, timeout_err, overrun_err, rd_data},
          0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h09); exp_q.push_back(8'h01); exp_q.push_back(8'h77);
    stim_q = '{8'hFE, 8'h09, 8'h01, 8'h77, 8'hEF};
    send_stim();
    expect_pkt();
    ack_pkt();

    check("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
